pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
// - Hazard controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
// - Tracks in-flight destination registers in a 3-entry scoreboard (EX, MEM, WB).
// - Generates load-use stalls, branch/jump flushes and EX operand-forwarding selects.
// - Keeps saturating stall/flush performance counters. Sits beside the stage flops and drives their hold/clear controls.
// PARAMETERS
// - LOAD_LAT     1   stall cycles for a load-use hazard (synchronous DMEM read); range 1..3
// - FLUSH_CYCLES 1   extra IF/ID flush cycles after a redirect (registered IMEM output); range 0..3
// - CNT_W        16  width of the perf counters
// PORTS
// - CLK          in   1      sole clock, rising edge
// - RESET        in   1      asynchronous, active-low; clears all state
// - id_valid     in   1      ID stage holds a real instruction
// - id_rs1       in   5      ID source register 1
// - id_rs2       in   5      ID source register 2
// - id_use_rs1   in   1      ID instruction reads rs1
// - id_use_rs2   in   1      ID instruction reads rs2
// - id_rd        in   5      ID destination register
// - id_regwen    in   1      ID instruction writes rd (RegWEn)
// - id_is_load   in   1      ID instruction is a load (WBSel = DMEM)
// - ex_redirect  in   1      EX resolved a taken branch or jump (PCSel)
// - stall_if     out  1      hold PC and IF/ID register
// - stall_id     out  1      hold ID/EX source fields
// - bubble_ex    out  1      load NOP (all write enables 0) into ID/EX
// - flush_if_id  out  1      clear IF/ID to NOP
// - fwd_a        out  2      EX operand A select: 00 regfile, 01 MEM ALU result, 10 WB mux
// - fwd_b        out  2      EX operand B select, same encoding
// - stall_count  out  CNT_W  saturating count of stall cycles
// - flush_count  out  CNT_W  saturating count of redirects
// BEHAVIOUR
// - Reset (RESET=0, async): state=RUN, scoreboard invalid, counters 0; all outputs 0 / 2'b00.
// - Scoreboard entry: {valid, rd, regwen, is_load}. Advances every cycle: WB<=MEM, MEM<=EX.
//   - EX<=ID fields when id_valid & !bubble_ex; otherwise EX<=invalid.
// - Hazard match: entry valid & regwen & rd!=0 & rd==src & use_src.
// - FSM states: RUN, LU_STALL, FLUSH.
// - RUN, ex_redirect=1: combinationally flush_if_id=1 and bubble_ex=1 this cycle.
//   - flush_count += 1.
//   - If FLUSH_CYCLES>0, go to FLUSH with cnt=FLUSH_CYCLES-1.
// - RUN, no redirect, EX entry is a load matching an ID source: stall_if=stall_id=bubble_ex=1.
//   - stall_count += 1.
//   - If LOAD_LAT>1, go to LU_STALL with cnt=LOAD_LAT-2.
// - LU_STALL: stall_if=stall_id=bubble_ex=1; stall_count += 1 each cycle; cnt==0 -> RUN, else cnt-1.
// - FLUSH: flush_if_id=1, bubble_ex=1; cnt==0 -> RUN, else cnt-1.
// - Simultaneous events: ex_redirect beats any stall in every state.
//   - It aborts LU_STALL or restarts FLUSH; the stall is dropped and flush_count increments.
// - Forwarding (combinational, evaluated against the MEM and WB entries):
//   - MEM match & !is_load -> 01; else WB match -> 10; else 00. MEM has priority over WB.
//   - A load in MEM is never forwarded from MEM; the stall logic guarantees it reaches WB first.
//   - On a WB match the 10 select is used even though the regfile writes that cycle; write-first regfile behaviour is not relied on.
// - rd==x0 never stalls and never forwards.
// - Counters saturate at 2^CNT_W-1 and do not wrap.
// - Reset mid-stall or mid-flush: immediate return to RUN with outputs at reset values.
// STRUCTURE
// - Shared package pipe_pkg:
//   - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
//   - hz_state_t {RUN, LU_STALL, FLUSH}
//   - sb_entry_t struct
// - Sub-module hazard_scoreboard: 3-entry shift register with insert and bubble inputs; exposes the EX/MEM/WB entries.
// - Top: FSM, down-counter, forwarding compare, perf counters.
// TESTING
// - 1. Back-to-back ALU ops: add x5 then sub x6,x5,x1 -> fwd_a=01 next cycle, no stall.
//   - Add one independent op between them -> fwd_a=10.
// - 2. Load-use: lw x7 then add x8,x7,x7, LOAD_LAT=1 -> exactly 1 cycle of stall_if=bubble_ex=1.
//   - The next cycle gives fwd_a=fwd_b=10; stall_count=1.
// - 3. Taken branch with FLUSH_CYCLES=1 -> flush_if_id high for 2 consecutive cycles, bubble_ex high for 2 cycles; flush_count=1.
// - 4. Redirect in the same cycle as a load-use match -> no stall; flush behaviour as in test 3; stall_count unchanged.
// - 5. Writes to x0 (add x0 then use x0) -> fwd=00 and no stall.
//   - RESET pulsed low during LU_STALL with LOAD_LAT=3 -> all outputs 0 asynchronously; RUN afterwards.
// - 6. Force stall_count to 16'hFFFE, then 3 stall cycles -> value holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the pipeline hazard controller
package pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} hz_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwen;
        logic       is_load;
    } sb_entry_t;

    typedef struct packed {
        logic       use_rs1;
        logic [4:0] rs1;
        logic       use_rs2;
        logic [4:0] rs2;
    } ex_src_t;

    function automatic logic sb_hit(sb_entry_t e, logic [4:0] src, logic use_src);
        return e.valid && e.regwen && (e.rd != 5'd0) && (e.rd == src) && use_src;
    endfunction

    // A load sitting in MEM has no data yet, so it is skipped and only WB may supply it.
    function automatic logic [1:0] fwd_select(sb_entry_t mem_e, sb_entry_t wb_e,
                                              logic [4:0] src, logic use_src);
        if (sb_hit(mem_e, src, use_src) && !mem_e.is_load) return FWD_MEM;
        if (sb_hit(wb_e, src, use_src)) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - ID-stage inputs and hazard control outputs
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       id_rd;
    logic             id_regwen;
    logic             id_is_load;
    logic             ex_redirect;
    logic             stall_if;
    logic             stall_id;
    logic             bubble_ex;
    logic             flush_if_id;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwen, id_is_load, ex_redirect,
        input  stall_if, stall_id, bubble_ex, flush_if_id, fwd_a, fwd_b,
               stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwen, id_is_load, ex_redirect,
        output stall_if, stall_id, bubble_ex, flush_if_id, fwd_a, fwd_b,
               stall_count, flush_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - three-entry EX/MEM/WB destination scoreboard
module hazard_scoreboard
    import pipe_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      insert_i,
    input  logic      bubble_i,
    input  sb_entry_t id_entry_i,
    output sb_entry_t ex_o,
    output sb_entry_t mem_o,
    output sb_entry_t wb_o
);

    sb_entry_t ex_q, mem_q, wb_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= (insert_i && !bubble_i) ? id_entry_i : '0;
        end
    end

    assign ex_o  = ex_q;
    assign mem_o = mem_q;
    assign wb_o  = wb_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, redirect flush and EX forwarding control
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam int LU_INIT    = (LOAD_LAT > 1) ? LOAD_LAT - 2 : 0;
    localparam int FLUSH_INIT = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;

    hz_state_t        state_q;
    logic [1:0]       cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    ex_src_t          ex_src_q;
    ex_src_t          id_src;
    sb_entry_t        id_entry, ex_e, mem_e, wb_e;
    logic             load_use;
    logic             stall;
    logic             flush;

    assign id_entry = '{valid: 1'b1, rd: hz.id_rd, regwen: hz.id_regwen, is_load: hz.id_is_load};
    assign id_src   = '{use_rs1: hz.id_use_rs1, rs1: hz.id_rs1,
                        use_rs2: hz.id_use_rs2, rs2: hz.id_rs2};

    hazard_scoreboard u_sb (
        .clk_i      (CLK),
        .rst_ni     (RESET),
        .insert_i   (hz.id_valid),
        .bubble_i   (hz.bubble_ex),
        .id_entry_i (id_entry),
        .ex_o       (ex_e),
        .mem_o      (mem_e),
        .wb_o       (wb_e)
    );

    assign load_use = ex_e.is_load &&
                      (sb_hit(ex_e, hz.id_rs1, hz.id_use_rs1) ||
                       sb_hit(ex_e, hz.id_rs2, hz.id_use_rs2));

    // Redirect outranks everything; outputs are held low while reset is asserted.
    always_comb begin
        flush = 1'b0;
        stall = 1'b0;
        if (RESET) begin
            if (hz.ex_redirect || state_q == FLUSH) begin
                flush = 1'b1;
            end else if (state_q == LU_STALL || load_use) begin
                stall = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= RUN;
            cnt_q       <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (hz.ex_redirect) begin
            if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (FLUSH_CYCLES > 0) begin
                state_q <= FLUSH;
                cnt_q   <= 2'(FLUSH_INIT);
            end else begin
                state_q <= RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (load_use) begin
                        if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                        if (LOAD_LAT > 1) begin
                            state_q <= LU_STALL;
                            cnt_q   <= 2'(LU_INIT);
                        end
                    end
                end
                LU_STALL: begin
                    if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                    if (cnt_q == 2'd0) state_q <= RUN;
                    else               cnt_q   <= cnt_q - 2'd1;
                end
                FLUSH: begin
                    if (cnt_q == 2'd0) state_q <= RUN;
                    else               cnt_q   <= cnt_q - 2'd1;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // Source fields of the instruction now in EX; a bubble carries no sources.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) ex_src_q <= '0;
        else        ex_src_q <= (hz.id_valid && !hz.bubble_ex) ? id_src : '0;
    end

    assign hz.stall_if    = stall;
    assign hz.stall_id    = stall;
    assign hz.bubble_ex   = stall | flush;
    assign hz.flush_if_id = flush;
    assign hz.fwd_a       = fwd_select(mem_e, wb_e, ex_src_q.rs1, ex_src_q.use_rs1);
    assign hz.fwd_b       = fwd_select(mem_e, wb_e, ex_src_q.rs2, ex_src_q.use_rs2);
    assign hz.stall_count = stall_cnt_q;
    assign hz.flush_count = flush_cnt_q;

endmodule
